// File: rtl/fhe_dbg_pkg.sv
// Shared types for the in-fabric AXI trace monitor: event ids, capture FSM states, entry header layout.
package fhe_dbg_pkg;

   localparam int TS_W    = 32;
   localparam int CH_ID_W = 4;
   localparam int EVT_N   = 5;

   typedef enum logic [2:0] {
      EVT_AW = 3'd0,
      EVT_W  = 3'd1,
      EVT_AR = 3'd2,
      EVT_R  = 3'd3,
      EVT_B  = 3'd4
   } evt_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRETRIG  = 2'd1,
      POSTTRIG = 2'd2,
      DONE     = 2'd3
   } trace_state_e;

   // Fixed-width header of a trace entry; the probe field follows it and the optional timestamp precedes it.
   typedef struct packed {
      logic [CH_ID_W-1:0] ch_id;
      logic [EVT_N-1:0]   evt;
   } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one registered read port (read-first on collision).
module trace_ram #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10,
   parameter int WIDTH  = 73
)(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_q
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_q <= mem[rd_addr];
   end

endmodule

// File: rtl/axi_trace_monitor.sv
// Multi-channel AXI handshake trace monitor with trigger window, drop and beat counters.
// Optional feature: define TRACE_TIMESTAMP_EN to prefix every entry with a 32-bit cycle stamp.
module axi_trace_monitor
   import fhe_dbg_pkg::*;
#(
   parameter int NUM_CH  = 5,
   parameter int DEPTH   = 1024,
   parameter int PROBE_W = 64,
   parameter int CNT_W   = 32,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef TRACE_TIMESTAMP_EN
   localparam int STAMP_W = TS_W,
`else
   localparam int STAMP_W = 0,
`endif
   localparam int ENTRY_W = STAMP_W + CH_ID_W + EVT_N + PROBE_W
)(
   input  logic                             aclk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0][EVT_N-1:0]     ch_valid,
   input  logic [NUM_CH-1:0][EVT_N-1:0]     ch_ready,
   input  logic [NUM_CH-1:0][PROBE_W-1:0]   ch_probe,
   input  logic                             ctl_arm,
   input  logic                             ctl_clear,
   input  logic [NUM_CH-1:0]                ctl_ch_en,
   input  logic [CH_W-1:0]                  ctl_trig_ch,
   input  logic [EVT_N-1:0]                 ctl_trig_evt,
   input  logic [ADDR_W-1:0]                ctl_post,
   input  logic                             rd_en,
   input  logic [ADDR_W-1:0]                rd_addr,
   output logic [ENTRY_W-1:0]               rd_data,
   output logic                             rd_valid,
   output logic [1:0]                       st_state,
   output logic [ADDR_W:0]                  st_count,
   output logic [CNT_W-1:0]                 st_drop,
   output logic [NUM_CH-1:0][CNT_W-1:0]     beat_cnt
);

   localparam int NFIRE_W = $clog2(NUM_CH * EVT_N + 1);

   trace_state_e               state_reg;
   logic [ADDR_W-1:0]          wr_ptr_reg;
   logic [ADDR_W-1:0]          post_cnt_reg;
   logic [ADDR_W:0]            count_reg;
   logic [CNT_W-1:0]           drop_reg;
   logic                       rd_valid_reg;

   logic [NUM_CH-1:0][EVT_N-1:0] fire;
   logic                       any_fire;
   logic                       trig_hit;
   logic                       capture;
   logic                       wr_en;
   logic [NFIRE_W-1:0]         n_fire;
   logic [CH_ID_W-1:0]         win_ch;
   logic [EVT_N-1:0]           win_evt;
   logic [PROBE_W-1:0]         win_probe;
   trace_entry_t               win_hdr;
   logic [ENTRY_W-1:0]         wr_data;
   logic [ENTRY_W-1:0]         ram_q;
   logic [ADDR_W-1:0]          rd_ptr;
   logic [CNT_W:0]             drop_sum;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fire
         assign fire[gi] = ch_valid[gi] & ch_ready[gi] & {EVT_N{ctl_ch_en[gi]}};
      end
   endgenerate

   // Scan from the top so the lowest (channel, event) index is the last to overwrite the winner.
   always_comb begin
      any_fire  = 1'b0;
      trig_hit  = 1'b0;
      n_fire    = '0;
      win_ch    = '0;
      win_evt   = '0;
      win_probe = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         for (int e = EVT_N - 1; e >= 0; e--) begin
            if (fire[c][e]) begin
               n_fire    = n_fire + NFIRE_W'(1);
               any_fire  = 1'b1;
               win_ch    = CH_ID_W'(c);
               win_evt   = EVT_N'(1) << e;
               win_probe = ch_probe[c];
            end
         end
         if (ctl_trig_ch == CH_W'(c) && |(fire[c] & ctl_trig_evt))
            trig_hit = 1'b1;
      end
   end

   assign win_hdr  = '{ch_id: win_ch, evt: win_evt};
   assign capture  = (state_reg == PRETRIG) ||
                     (state_reg == POSTTRIG && post_cnt_reg != ctl_post);
   assign wr_en    = capture && any_fire && !ctl_clear;
   assign drop_sum = {1'b0, drop_reg} + (CNT_W + 1)'(n_fire) - (CNT_W + 1)'(1);
   assign rd_ptr   = wr_ptr_reg - count_reg[ADDR_W-1:0] + rd_addr;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_reg;

   always_ff @(posedge aclk or posedge rst) begin
      if (rst)
         ts_reg <= '0;
      else if (ctl_clear)
         ts_reg <= '0;
      else
         ts_reg <= ts_reg + TS_W'(1);
   end

   assign wr_data = {ts_reg, win_hdr, win_probe};
`else
   assign wr_data = {win_hdr, win_probe};
`endif

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         drop_reg     <= '0;
         post_cnt_reg <= '0;
      end else if (ctl_clear) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         drop_reg     <= '0;
         post_cnt_reg <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            if (count_reg != (ADDR_W + 1)'(DEPTH))
               count_reg <= count_reg + (ADDR_W + 1)'(1);
            drop_reg <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
         end
         case (state_reg)
            IDLE: begin
               if (ctl_arm) begin
                  state_reg    <= PRETRIG;
                  post_cnt_reg <= '0;
               end
            end
            PRETRIG: begin
               if (trig_hit) begin
                  state_reg    <= POSTTRIG;
                  post_cnt_reg <= '0;
               end
            end
            POSTTRIG: begin
               // The trigger entry was written in PRETRIG, so only later writes advance the window.
               if (post_cnt_reg == ctl_post)
                  state_reg <= DONE;
               else if (any_fire)
                  post_cnt_reg <= post_cnt_reg + ADDR_W'(1);
            end
            DONE: begin
               if (ctl_arm) begin
                  state_reg    <= PRETRIG;
                  post_cnt_reg <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst)
         rd_valid_reg <= 1'b0;
      else
         rd_valid_reg <= rd_en;
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_beat
         logic [CNT_W-1:0] cnt_reg;
         logic [1:0]       inc;
         logic [CNT_W:0]   sum;

         assign inc = {1'b0, ch_valid[gi][EVT_W] & ch_ready[gi][EVT_W]} +
                      {1'b0, ch_valid[gi][EVT_R] & ch_ready[gi][EVT_R]};
         assign sum = {1'b0, cnt_reg} + (CNT_W + 1)'(inc);

         always_ff @(posedge aclk or posedge rst) begin
            if (rst)
               cnt_reg <= '0;
            else if (ctl_clear)
               cnt_reg <= '0;
            else
               cnt_reg <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
         end

         assign beat_cnt[gi] = cnt_reg;
      end
   endgenerate

   trace_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (ENTRY_W)
   ) u_trace_ram (
      .clk     (aclk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_reg),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_q    (ram_q)
   );

   // The RAM output register has no reset, so the port is held at zero outside the valid cycle.
   assign rd_data  = rd_valid_reg ? ram_q : '0;
   assign rd_valid = rd_valid_reg;
   assign st_state = state_reg;
   assign st_count = count_reg;
   assign st_drop  = drop_reg;

endmodule
